// File: rtl/layer_output_serializer_pkg.sv
// Shared types and widths for the layer output serializer.
// Supplies `dataWidth/`ROM_bitwidth defaults and the SER state encoding.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif

package layer_output_serializer_pkg;

  typedef enum logic {
    SER_COLLECT = 1'b0,
    SER_SEND    = 1'b1
  } ser_state_e;

endpackage

// File: rtl/layer_output_serializer_if.sv
// Serialized beat stream from the serializer to the next layer.
// master drives data/valid/last/idx, slave drives out_ready.
interface layer_output_serializer_if #(
  parameter int OUT_WIDTH = 16,
  parameter int IDX_WIDTH = 4
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [IDX_WIDTH-1:0] out_idx;

  modport master (
    output out_data, out_valid, out_last, out_idx,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_last, out_idx,
    output out_ready
  );
endinterface

// File: rtl/layer_output_serializer_argmax.sv
// layer_argmax_tracker: running unsigned max over a frame's captures.
// Ports: clk, rst(sync low), cap/vals in, clr/load ctl, argmax_idx/valid out.
import layer_output_serializer_pkg::*;

module layer_argmax_tracker #(
  parameter int NUM_NEURONS = 10,
  parameter int IN_WIDTH    = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_NEURONS-1:0]        cap,
  input  logic [NUM_NEURONS*IN_WIDTH-1:0] vals,
  input  logic                          clr,
  input  logic                          load,
  output logic [IDX_WIDTH-1:0]          argmax_idx,
  output logic                          argmax_valid
);

  logic                 have_q, have_d;
  logic [IN_WIDTH-1:0]  max_q, max_d;
  logic [IDX_WIDTH-1:0] run_q, run_d;
  logic [IDX_WIDTH-1:0] aidx_q, aidx_d;
  logic                 avld_q, avld_d;

  // Ascending scan; equal values from a lower index win even
  // when the higher index arrived in an earlier cycle.
  always_comb begin
    have_d = have_q;
    max_d  = max_q;
    run_d  = run_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (cap[i]) begin
        if (!have_d
            || vals[i*IN_WIDTH +: IN_WIDTH] > max_d
            || (vals[i*IN_WIDTH +: IN_WIDTH] == max_d
                && IDX_WIDTH'(i) < run_d)) begin
          have_d = 1'b1;
          max_d  = vals[i*IN_WIDTH +: IN_WIDTH];
          run_d  = IDX_WIDTH'(i);
        end
      end
    end
    if (clr) have_d = 1'b0;
    aidx_d = load ? run_q : aidx_q;
    avld_d = load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      have_q <= 1'b0;
      max_q  <= '0;
      run_q  <= '0;
      aidx_q <= '0;
      avld_q <= 1'b0;
    end else begin
      have_q <= have_d;
      max_q  <= max_d;
      run_q  <= run_d;
      aidx_q <= aidx_d;
      avld_q <= avld_d;
    end
  end

  assign argmax_idx   = aidx_q;
  assign argmax_valid = avld_q;

endmodule

// File: rtl/layer_output_serializer.sv
// Captures a layer's neuron outputs, replays them one beat per accept.
// Ports: clk, rst(sync low), neuron_out/valid in, out_if stream, overflow,
// argmax_idx/argmax_valid only when LAYER_SER_ARGMAX_EN is defined.
import layer_output_serializer_pkg::*;

module layer_output_serializer #(
  parameter int NUM_NEURONS = 10,
  parameter int IN_WIDTH    = `ROM_bitwidth,
  parameter int OUT_WIDTH   = `dataWidth,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS*IN_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]          neuron_valid,
  layer_output_serializer_if.master       out_if,
`ifdef LAYER_SER_ARGMAX_EN
  output logic [IDX_WIDTH-1:0]            argmax_idx,
  output logic                            argmax_valid,
`endif
  output logic                            overflow
);

  if (IN_WIDTH > OUT_WIDTH) begin : g_width_chk
    $error("IN_WIDTH must not exceed OUT_WIDTH");
  end

  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(NUM_NEURONS - 1);

  ser_state_e           state_q, state_d;
  logic [NUM_NEURONS-1:0] got_q, got_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 vld_q, vld_d;
  logic [OUT_WIDTH-1:0] dat_q, dat_d;
  logic                 ovf_q, ovf_d;
  logic [IN_WIDTH-1:0]  act_q [NUM_NEURONS];
  logic [IN_WIDTH-1:0]  act_d [NUM_NEURONS];

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    ovf_d   = ovf_q;
    act_d   = act_q;
    unique case (state_q)
      SER_COLLECT: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (neuron_valid[i]) begin
            if (!got_q[i]) begin
              act_d[i] = neuron_out[i*IN_WIDTH +: IN_WIDTH];
              got_d[i] = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        if (&got_d) state_d = SER_SEND;
      end
      SER_SEND: begin
        if (|neuron_valid) ovf_d = 1'b1;
        // First SEND cycle only loads beat 0 into the output regs.
        if (!vld_q) begin
          vld_d = 1'b1;
          dat_d = OUT_WIDTH'(act_q[idx_q]);
        end else if (out_if.out_ready) begin
          if (idx_q == LAST) begin
            vld_d   = 1'b0;
            dat_d   = '0;
            idx_d   = '0;
            got_d   = '0;
            state_d = SER_COLLECT;
          end else begin
            idx_d = idx_q + 1'b1;
            dat_d = OUT_WIDTH'(act_q[idx_d]);
          end
        end
      end
      default: state_d = SER_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SER_COLLECT;
      got_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    act_q <= act_d;
  end

  assign out_if.out_valid = vld_q;
  assign out_if.out_data  = dat_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = vld_q && (idx_q == LAST);
  assign overflow         = ovf_q;

`ifdef LAYER_SER_ARGMAX_EN
  logic [NUM_NEURONS-1:0] am_cap;
  logic                   am_clr;
  logic                   am_load;

  assign am_cap  = (state_q == SER_COLLECT)
                   ? (neuron_valid & ~got_q) : '0;
  assign am_clr  = (state_q == SER_SEND) && vld_q
                   && out_if.out_ready && (idx_q == LAST);
  assign am_load = (state_q == SER_SEND) && !vld_q;

  layer_argmax_tracker #(
    .NUM_NEURONS (NUM_NEURONS),
    .IN_WIDTH    (IN_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .cap          (am_cap),
    .vals         (neuron_out),
    .clr          (am_clr),
    .load         (am_load),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );
`endif

endmodule
